// File: rtl/decode_pipe_regs_if.sv
// Bus bundle between the decode-side pipeline registers and their neighbours
// (fetch, decoder, hazard unit, execute). The register block uses the slave modport.
interface decode_pipe_regs_if;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;
    logic [31:0] id_imm;
    logic [8:0]  id_ctrl;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc4;
    logic [8:0]  ex_ctrl;
    logic        MemToReg_EX;
    logic        ex_valid;
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;

    modport master (
        output StallD, FlushD, FlushE, if_instr, if_pc4, if_valid,
               id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_ctrl,
        input  id_instr, id_pc4, id_valid,
               ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc4,
               ex_ctrl, MemToReg_EX, ex_valid, stall_cnt, bubble_cnt
    );

    modport slave (
        input  StallD, FlushD, FlushE, if_instr, if_pc4, if_valid,
               id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm, id_ctrl,
        output id_instr, id_pc4, id_valid,
               ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc4,
               ex_ctrl, MemToReg_EX, ex_valid, stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/decode_pipe_regs.sv
// IF/ID and ID/EX pipeline registers with stall/flush handling.
// Optional stall/bubble statistics counters enabled by `DECODE_PIPE_STATS_EN.
module decode_pipe_regs (
    input  logic               clk,
    input  logic               rst_n,
    decode_pipe_regs_if.slave  bus
);

    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q,   id_pc4_d;
    logic        id_valid_q, id_valid_d;

    logic [4:0]  ex_rs_q,  ex_rs_d;
    logic [4:0]  ex_rt_q,  ex_rt_d;
    logic [4:0]  ex_rd_q,  ex_rd_d;
    logic [31:0] ex_rd1_q, ex_rd1_d;
    logic [31:0] ex_rd2_q, ex_rd2_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [31:0] ex_pc4_q, ex_pc4_d;
    logic [8:0]  ex_ctrl_q, ex_ctrl_d;
    logic        ex_valid_q, ex_valid_d;

    // IF/ID: hold beats flush; a flush inserts sll $0,$0,0 marked invalid.
    always_comb begin
        id_instr_d = bus.if_instr;
        id_pc4_d   = bus.if_pc4;
        id_valid_d = bus.if_valid;
        if (!bus.StallD) begin
            id_instr_d = id_instr_q;
            id_pc4_d   = id_pc4_q;
            id_valid_d = id_valid_q;
        end else if (bus.FlushD) begin
            id_instr_d = 32'd0;
            id_pc4_d   = 32'd0;
            id_valid_d = 1'b0;
        end
    end

    // ID/EX never holds; a bubble zeroes everything so it cannot write state.
    always_comb begin
        ex_rs_d    = bus.id_rs;
        ex_rt_d    = bus.id_rt;
        ex_rd_d    = bus.id_rd;
        ex_rd1_d   = bus.id_rd1;
        ex_rd2_d   = bus.id_rd2;
        ex_imm_d   = bus.id_imm;
        ex_pc4_d   = id_pc4_q;
        ex_ctrl_d  = bus.id_ctrl;
        ex_valid_d = id_valid_q;
        if (bus.FlushE) begin
            ex_rs_d    = 5'd0;
            ex_rt_d    = 5'd0;
            ex_rd_d    = 5'd0;
            ex_rd1_d   = 32'd0;
            ex_rd2_d   = 32'd0;
            ex_imm_d   = 32'd0;
            ex_pc4_d   = 32'd0;
            ex_ctrl_d  = 9'd0;
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr_q <= 32'd0;
            id_pc4_q   <= 32'd0;
            id_valid_q <= 1'b0;
            ex_rs_q    <= 5'd0;
            ex_rt_q    <= 5'd0;
            ex_rd_q    <= 5'd0;
            ex_rd1_q   <= 32'd0;
            ex_rd2_q   <= 32'd0;
            ex_imm_q   <= 32'd0;
            ex_pc4_q   <= 32'd0;
            ex_ctrl_q  <= 9'd0;
            ex_valid_q <= 1'b0;
        end else begin
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd1_q   <= ex_rd1_d;
            ex_rd2_q   <= ex_rd2_d;
            ex_imm_q   <= ex_imm_d;
            ex_pc4_q   <= ex_pc4_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_valid_q <= ex_valid_d;
        end
    end

`ifdef DECODE_PIPE_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        stall_cnt_d  = bus.StallD ? stall_cnt_q : sat_inc(stall_cnt_q);
        bubble_cnt_d = bus.FlushE ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= 16'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
`else
    assign bus.stall_cnt  = 16'd0;
    assign bus.bubble_cnt = 16'd0;
`endif

    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc4      = id_pc4_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.ex_rs       = ex_rs_q;
    assign bus.ex_rt       = ex_rt_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_rd1      = ex_rd1_q;
    assign bus.ex_rd2      = ex_rd2_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_pc4      = ex_pc4_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.MemToReg_EX = ex_ctrl_q[1];
    assign bus.ex_valid    = ex_valid_q;

endmodule

// File: tb/tb_decode_pipe_regs.sv
// Bench for decode_pipe_regs: directed vector table, load-use/flush sequences,
// random stimulus against a transaction-level model, and saturation of the stats counters.
module tb_decode_pipe_regs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_pipe_regs_if bus ();
    decode_pipe_regs dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } id_slot_t;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, rd2, imm, pc4;
        logic [8:0]  ctrl;
        logic        valid;
    } ex_slot_t;

    id_slot_t m_id;
    ex_slot_t m_ex;
    int       m_stall_cnt;
    int       m_bubble_cnt;

    // Tiny decoder: lw and R-type add get real control words, others none.
    function automatic logic [8:0] dec_ctrl(input logic [31:0] ins);
        if (ins[31:26] == 6'h23) return 9'h04B;
        if (ins[31:26] == 6'h00 && ins != 32'd0) return 9'h051;
        return 9'h000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_decode();
        bus.id_rs   = m_id.instr[25:21];
        bus.id_rt   = m_id.instr[20:16];
        bus.id_rd   = m_id.instr[15:11];
        bus.id_ctrl = dec_ctrl(m_id.instr);
        bus.id_rd1  = $urandom;
        bus.id_rd2  = $urandom;
        bus.id_imm  = $urandom;
    endtask

    task automatic model_reset();
        m_id = '{instr: 32'd0, pc4: 32'd0, valid: 1'b0};
        m_ex = '{rs: 5'd0, rt: 5'd0, rd: 5'd0, rd1: 32'd0, rd2: 32'd0,
                 imm: 32'd0, pc4: 32'd0, ctrl: 9'd0, valid: 1'b0};
        m_stall_cnt  = 0;
        m_bubble_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".id_instr"}, bus.id_instr, m_id.instr);
        chk({tag, ".id_pc4"},   bus.id_pc4,   m_id.pc4);
        chk({tag, ".id_valid"}, {31'd0, bus.id_valid}, {31'd0, m_id.valid});
        chk({tag, ".ex_rs"},    {27'd0, bus.ex_rs}, {27'd0, m_ex.rs});
        chk({tag, ".ex_rt"},    {27'd0, bus.ex_rt}, {27'd0, m_ex.rt});
        chk({tag, ".ex_rd"},    {27'd0, bus.ex_rd}, {27'd0, m_ex.rd});
        chk({tag, ".ex_rd1"},   bus.ex_rd1, m_ex.rd1);
        chk({tag, ".ex_rd2"},   bus.ex_rd2, m_ex.rd2);
        chk({tag, ".ex_imm"},   bus.ex_imm, m_ex.imm);
        chk({tag, ".ex_pc4"},   bus.ex_pc4, m_ex.pc4);
        chk({tag, ".ex_ctrl"},  {23'd0, bus.ex_ctrl}, {23'd0, m_ex.ctrl});
        chk({tag, ".MemToReg_EX"}, {31'd0, bus.MemToReg_EX}, {31'd0, m_ex.ctrl[1]});
        chk({tag, ".ex_valid"}, {31'd0, bus.ex_valid}, {31'd0, m_ex.valid});
        chk({tag, ".stall_cnt"},  {16'd0, bus.stall_cnt},  32'(m_stall_cnt));
        chk({tag, ".bubble_cnt"}, {16'd0, bus.bubble_cnt}, 32'(m_bubble_cnt));
    endtask

    // One clock: next state is computed from the inputs before the edge,
    // committed and compared 1 time unit after it.
    task automatic step(input bit do_check, input string tag);
        id_slot_t n_id;
        ex_slot_t n_ex;
        if (!bus.StallD)     n_id = m_id;
        else if (bus.FlushD) n_id = '{instr: 32'd0, pc4: 32'd0, valid: 1'b0};
        else                 n_id = '{instr: bus.if_instr, pc4: bus.if_pc4, valid: bus.if_valid};
        if (bus.FlushE)
            n_ex = '{rs: 5'd0, rt: 5'd0, rd: 5'd0, rd1: 32'd0, rd2: 32'd0,
                     imm: 32'd0, pc4: 32'd0, ctrl: 9'd0, valid: 1'b0};
        else
            n_ex = '{rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd, rd1: bus.id_rd1,
                     rd2: bus.id_rd2, imm: bus.id_imm, pc4: m_id.pc4,
                     ctrl: bus.id_ctrl, valid: m_id.valid};
`ifdef DECODE_PIPE_STATS_EN
        if (!bus.StallD && m_stall_cnt < 65535) m_stall_cnt++;
        if (bus.FlushE && m_bubble_cnt < 65535) m_bubble_cnt++;
`endif
        @(posedge clk);
        #1;
        m_id = n_id;
        m_ex = n_ex;
        if (do_check) check_all(tag);
        drive_decode();
    endtask

    task automatic set_ctl(input logic s, input logic fd, input logic fe);
        bus.StallD = s;
        bus.FlushD = fd;
        bus.FlushE = fe;
    endtask

    typedef struct {
        logic        stall, flushd, flushe;
        logic [31:0] instr, pc4;
        logic        valid;
        logic [31:0] e_id_instr;
        logic        e_id_valid;
        logic [8:0]  e_ex_ctrl;
        logic        e_ex_valid;
        logic [4:0]  e_ex_rt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Directed pipeline walk: lw, dependent add with load-use stall, flushes.
        vecs[0] = '{1, 0, 0, 32'h8C220004, 32'd4,  1, 32'h8C220004, 1, 9'h000, 0, 5'd0};
        vecs[1] = '{1, 0, 0, 32'h00432020, 32'd8,  1, 32'h00432020, 1, 9'h04B, 1, 5'd2};
        vecs[2] = '{0, 0, 1, 32'h2002000A, 32'd12, 1, 32'h00432020, 1, 9'h000, 0, 5'd0};
        vecs[3] = '{1, 0, 0, 32'h2002000A, 32'd12, 1, 32'h2002000A, 1, 9'h051, 1, 5'd3};
        vecs[4] = '{1, 1, 0, 32'h12345678, 32'd16, 1, 32'h00000000, 0, 9'h000, 1, 5'd2};
        vecs[5] = '{1, 0, 0, 32'h8C220004, 32'd16, 1, 32'h8C220004, 1, 9'h000, 0, 5'd0};
        vecs[6] = '{0, 1, 1, 32'hDEADBEEF, 32'd20, 1, 32'h8C220004, 1, 9'h000, 0, 5'd0};
        vecs[7] = '{0, 0, 0, 32'hDEADBEEF, 32'd20, 1, 32'h8C220004, 1, 9'h04B, 1, 5'd2};

        // Reset with nonzero inputs.
        set_ctl(1, 0, 0);
        bus.if_instr = 32'hFFFF_FFFF;
        bus.if_pc4   = 32'h1234_5678;
        bus.if_valid = 1'b1;
        model_reset();
        drive_decode();
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            set_ctl(vecs[i].stall, vecs[i].flushd, vecs[i].flushe);
            bus.if_instr = vecs[i].instr;
            bus.if_pc4   = vecs[i].pc4;
            bus.if_valid = vecs[i].valid;
            step(1'b1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.id_instr", i), bus.id_instr, vecs[i].e_id_instr);
            chk($sformatf("vec%0d.id_valid", i), {31'd0, bus.id_valid}, {31'd0, vecs[i].e_id_valid});
            chk($sformatf("vec%0d.ex_ctrl", i), {23'd0, bus.ex_ctrl}, {23'd0, vecs[i].e_ex_ctrl});
            chk($sformatf("vec%0d.ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].e_ex_valid});
            chk($sformatf("vec%0d.ex_rt", i), {27'd0, bus.ex_rt}, {27'd0, vecs[i].e_ex_rt});
            chk($sformatf("vec%0d.MemToReg", i), {31'd0, bus.MemToReg_EX}, {31'd0, vecs[i].e_ex_ctrl[1]});
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_ctl(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 4) == 0));
            bus.if_instr = ($urandom_range(0, 2) == 0) ? 32'h8C000000 | ($urandom & 32'h03FF_FFFF)
                                                       : $urandom;
            bus.if_pc4   = $urandom;
            bus.if_valid = $urandom_range(0, 1);
            step(1'b1, "rand");
        end

        // Asynchronous reset mid-cycle: outputs clear with no clock edge.
        bus.if_instr = 32'hA5A5_A5A5;
        bus.if_valid = 1'b1;
        set_ctl(1, 0, 0);
        step(1'b0, "pre");
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive_decode();

`ifdef DECODE_PIPE_STATS_EN
        // Both counters pushed past saturation.
        set_ctl(0, 0, 1);
        for (int i = 0; i < 70000; i++) step(1'b0, "sat");
        chk("stall_cnt_sat",  {16'd0, bus.stall_cnt},  32'h0000_FFFF);
        chk("bubble_cnt_sat", {16'd0, bus.bubble_cnt}, 32'h0000_FFFF);
        step(1'b1, "sat_hold");
        chk("stall_cnt_hold", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
`else
        set_ctl(0, 0, 1);
        for (int i = 0; i < 20; i++) step(1'b0, "nostats");
        chk("stall_cnt_off",  {16'd0, bus.stall_cnt},  32'd0);
        chk("bubble_cnt_off", {16'd0, bus.bubble_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
